mp_addsub_seq: RTL and testbench

- Multi-precision add/subtract sequencer: one 8-bit carry-chain adder slice is time-shared across NBYTES byte lanes, LSB byte first.
- Operands are captured on a start handshake.
- The carry is held in a register between bytes.
- Sits between switch/UART operand capture logic and the 7-segment/LED result display on the board.

---
 rtl/mp_addsub_pkg.sv | 15 +
 rtl/mp_addsub_seq_if.sv | 38 +++
 rtl/mp_addsub_seq_add8_cell.sv | 34 +++
 rtl/mp_addsub_seq.sv | 153 +++++++++++++++
 tb/tb_mp_addsub_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mp_addsub_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_addsub_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Operand/result bus of mp_addsub_seq; the ovf signal exists only when
// MP_ADDSUB_OVF_EN is defined.
interface mp_addsub_seq_if #(
  parameter int unsigned NBYTES = 4
);

  logic                  start;
  logic                  op_sub;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  cout;
`ifdef MP_ADDSUB_OVF_EN
  logic                  ovf;

  modport master (
    output start, op_sub, a, b,
    input  ready, busy, done, result, cout, ovf
  );
  modport slave (
    input  start, op_sub, a, b,
    output ready, busy, done, result, cout, ovf
  );
`else
  modport master (
    output start, op_sub, a, b,
    input  ready, busy, done, result, cout
  );
  modport slave (
    input  start, op_sub, a, b,
    output ready, busy, done, result, cout
  );
`endif

endinterface

// File: rtl/mp_addsub_seq_add8_cell.sv
// Combinational 8-bit generate/propagate ripple slice. With MP_ADDSUB_OVF_EN
// it also exposes the carry into bit 7 for signed-overflow detection.
module add8_cell (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
`ifdef MP_ADDSUB_OVF_EN
  output logic       c7,
`endif
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

`ifdef MP_ADDSUB_OVF_EN
  assign c7 = c[7];
`endif

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one 8-bit slice walks NBYTES lanes,
// LSB first. Define MP_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  mp_addsub_seq_if.slave  bus
);

  localparam int unsigned W       = BYTE_W * NBYTES;
  localparam int unsigned IdxW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic              cout_q, cout_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      result_q, result_d;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] sum_byte;
  logic              slice_cout;
`ifdef MP_ADDSUB_OVF_EN
  logic              ovf_q, ovf_d;
  logic              slice_c7;
`endif

  // Lane select; B is inverted here so subtract reuses the adder.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
      end
    end
  end

  add8_cell u_add8_cell (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .sum  (sum_byte),
`ifdef MP_ADDSUB_OVF_EN
    .c7   (slice_c7),
`endif
    .cout (slice_cout)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.busy  = (state_q == StRun);
    bus.done  = (state_q == StDone);
  end

  // Datapath next state
  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    cout_d   = cout_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef MP_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (state_q == StIdle && bus.start) begin
      a_d     = bus.a;
      b_d     = bus.b;
      sub_d   = bus.op_sub;
      carry_d = (bus.op_sub == OP_SUB);
      idx_d   = '0;
    end else if (state_q == StRun) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (idx_q == IdxW'(i)) begin
          result_d[i*BYTE_W +: BYTE_W] = sum_byte;
        end
      end
      carry_d = slice_cout;
      if (idx_q == LastIdx) begin
        cout_d = slice_cout;
`ifdef MP_ADDSUB_OVF_EN
        ovf_d  = slice_c7 ^ slice_cout;
`endif
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      cout_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef MP_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      cout_q   <= cout_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef MP_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef MP_ADDSUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed bench for mp_addsub_seq: NBYTES=4 instance plus an NBYTES=1 instance.
module tb_mp_addsub_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mp_addsub_seq_if #(.NBYTES(4)) bus4 ();
  mp_addsub_seq_if #(.NBYTES(1)) bus1 ();

  mp_addsub_seq #(.NBYTES(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  mp_addsub_seq #(.NBYTES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start after a falling edge; returns just after the accepting edge.
  task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(negedge clk);
    bus4.a      = a;
    bus4.b      = b;
    bus4.op_sub = sub;
    bus4.start  = 1'b1;
    @(posedge clk);
    #1;
    bus4.start  = 1'b0;
    bus4.a      = 32'hDEAD_BEEF;
    bus4.b      = 32'h1234_5678;
  endtask

  // Counts falling edges until done is seen (lat = 0 on timeout).
  task automatic wait_done4(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus4.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic seen_done;

    vecs[0] = '{a: 32'h0000_00FF, b: 32'h0000_0001, sub: 1'b0, res: 32'h0000_0100, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, sub: 1'b0, res: 32'h0000_0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 32'h0000_0005, b: 32'h0000_0007, sub: 1'b1, res: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 32'h0000_0007, b: 32'h0000_0005, sub: 1'b1, res: 32'h0000_0002, cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, sub: 1'b0, res: 32'h8000_0000, cout: 1'b0, ovf: 1'b1};

    rst         = 1'b1;
    bus4.start  = 1'b0;
    bus4.op_sub = 1'b0;
    bus4.a      = '0;
    bus4.b      = '0;
    bus1.start  = 1'b0;
    bus1.op_sub = 1'b0;
    bus1.a      = '0;
    bus1.b      = '0;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready",  32'(bus4.ready), 32'd1);
    check_eq("rst_busy",   32'(bus4.busy),  32'd0);
    check_eq("rst_done",   32'(bus4.done),  32'd0);
    check_eq("rst_result", bus4.result,     32'd0);
    check_eq("rst_cout",   32'(bus4.cout),  32'd0);

    for (int v = 0; v < 5; v++) begin
      start4(vecs[v].a, vecs[v].b, vecs[v].sub);
      wait_done4(lat);
      check_eq($sformatf("v%0d_latency", v), 32'(lat), 32'd5);
      check_eq($sformatf("v%0d_result", v), bus4.result, vecs[v].res);
      check_eq($sformatf("v%0d_cout", v), 32'(bus4.cout), 32'(vecs[v].cout));
`ifdef MP_ADDSUB_OVF_EN
      check_eq($sformatf("v%0d_ovf", v), 32'(bus4.ovf), 32'(vecs[v].ovf));
`endif
      @(negedge clk);
      check_eq($sformatf("v%0d_done_pulse", v), 32'(bus4.done), 32'd0);
      check_eq($sformatf("v%0d_ready_after", v), 32'(bus4.ready), 32'd1);
      check_eq($sformatf("v%0d_result_hold", v), bus4.result, vecs[v].res);
    end

    // Start while busy must be ignored.
    start4(32'h0000_0010, 32'h0000_0020, 1'b0);
    @(negedge clk);
    check_eq("busy_flag",  32'(bus4.busy),  32'd1);
    check_eq("busy_ready", 32'(bus4.ready), 32'd0);
    @(posedge clk);
    #1;
    bus4.a      = 32'h0000_1000;
    bus4.b      = 32'h0000_0001;
    bus4.op_sub = 1'b1;
    bus4.start  = 1'b1;
    @(posedge clk);
    #1;
    bus4.start  = 1'b0;
    wait_done4(lat);
    check_eq("busy_latency", 32'(lat), 32'd3);
    check_eq("busy_result", bus4.result, 32'h0000_0030);
    check_eq("busy_cout",   32'(bus4.cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_no_second", 32'(bus4.done), 32'd0);

    // Asynchronous reset mid-RUN.
    start4(32'h1111_1111, 32'h2222_2222, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    check_eq("pre_rst_partial", {16'h0, bus4.result[15:0]}, 32'h0000_3333);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_result", bus4.result,    32'd0);
    check_eq("mid_rst_ready",  32'(bus4.ready), 32'd1);
    check_eq("mid_rst_busy",   32'(bus4.busy),  32'd0);
    check_eq("mid_rst_cout",   32'(bus4.cout),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus4.done) seen_done = 1'b1;
    end
    check_eq("mid_rst_no_done", 32'(seen_done), 32'd0);

    // Clean run after reset.
    start4(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done4(lat);
    check_eq("post_rst_result", bus4.result, 32'h2345_6789);

    // NBYTES=1 instance.
    @(negedge clk);
    bus1.a     = 8'hF0;
    bus1.b     = 8'h20;
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus1.done) begin
        lat = k;
        break;
      end
    end
    check_eq("n1_latency", 32'(lat), 32'd2);
    check_eq("n1_result",  {24'h0, bus1.result}, 32'h0000_0010);
    check_eq("n1_cout",    32'(bus1.cout), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
